// File: rtl/cim_aes_array_model.sv
// cim_aes_array_model: compute-in-memory array model behind the AES datapath.
// Each round runs a bit-serial AddRoundKey phase, then a per-lane table lookup.
module cim_aes_array_model #(
   parameter int NR      = 10,
   parameter int ARK_CYC = 8,
   parameter int RD_LAT  = 1,
   parameter int DMX_W   = 3,
   parameter int RWL_W   = 6,
   parameter int TBL_AW  = 8
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  start,
   input  logic                  dec,
   input  logic                  key_we,
   input  logic [3:0]            key_idx,
   input  logic [127:0]          key_wdata,
   input  logic                  tbl_we,
   input  logic [TBL_AW-1:0]     tbl_addr,
   input  logic [7:0]            tbl_wdata,
   input  logic [15:0]           IN,
   input  logic [16*DMX_W-1:0]   demux_add,
   input  logic [16*RWL_W-1:0]   rwl_add,
   output logic [127:0]          rio,
   output logic                  ark_phase,
   output logic                  lkp_vld,
   output logic [3:0]            rnd,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_err
);
   localparam logic [1:0] S_IDLE = 2'd0, S_ARK = 2'd1, S_LKP = 2'd2;

   logic [1:0]           r_st;
   logic [3:0]           r_cnt, r_rnd, w_kidx;
   logic                 r_dec, r_vld, r_done, r_err, w_idle, w_unused;
   logic [127:0]         r_rio, w_key, w_ark, w_lkp;
   logic [127:0]         r_key [0:NR];
   logic [7:0]           r_tbl [0:2**TBL_AW-1];
   logic [16*TBL_AW-1:0] w_addr, w_rd;

   assign w_idle    = r_st == S_IDLE;
   assign w_kidx    = r_dec ? 4'(NR) - r_rnd : r_rnd;
   assign w_key     = r_key[w_kidx];
   assign w_unused  = ^{demux_add, rwl_add};
   assign rio       = r_rio;
   assign ark_phase = r_st == S_ARK;
   assign lkp_vld   = r_vld;
   assign rnd       = r_rnd;
   assign busy      = !w_idle;
   assign done      = r_done;
   assign wr_err    = r_err;

   always_ff @(posedge CLK) begin
      if (key_we && w_idle && key_idx <= 4'(NR)) r_key[key_idx] <= key_wdata;
      if (tbl_we && w_idle) r_tbl[tbl_addr] <= tbl_wdata;
   end

   // Lane k takes bit k of the even key bytes, lane k+8 bit k of the odd bytes.
   always_comb begin
      w_ark = '0;
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 8; i++) begin
            w_ark[k*8 + 7 - i]     = w_key[120 - 16*i + k] ^ IN[k+8];
            w_ark[(k+8)*8 + 7 - i] = w_key[112 - 16*i + k] ^ IN[k];
         end
   end

   always_comb begin
      w_addr = '0;
      for (int j = 0; j < 16; j++)
         w_addr[j*TBL_AW +: TBL_AW] = TBL_AW'({demux_add[j*DMX_W +: DMX_W], rwl_add[j*RWL_W +: RWL_W]});
   end

   always_comb begin
      w_lkp = '0;
      for (int j = 0; j < 16; j++) w_lkp[j*8 +: 8] = r_tbl[w_rd[j*TBL_AW +: TBL_AW]];
   end

   generate
      if (RD_LAT == 1) begin : g_pipe
         assign w_rd = w_addr;
      end else begin : g_pipe
         logic [16*TBL_AW-1:0] r_pipe [0:RD_LAT-2];
         always_ff @(posedge CLK) begin
            if (!RSTn) begin
               for (int s = 0; s < RD_LAT-1; s++) r_pipe[s] <= '0;
            end else if (r_st == S_LKP) begin
               r_pipe[0] <= w_addr;
               for (int s = 1; s < RD_LAT-1; s++) r_pipe[s] <= r_pipe[s-1];
            end
         end
         assign w_rd = r_pipe[RD_LAT-2];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_st   <= S_IDLE;
         r_cnt  <= '0;
         r_rnd  <= '0;
         r_dec  <= 1'b0;
         r_rio  <= '0;
         r_vld  <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_vld  <= 1'b0;
         r_done <= 1'b0;
         r_err  <= (key_we || tbl_we) && !w_idle;
         case (r_st)
            S_IDLE: if (start) begin
               r_st  <= S_ARK;
               r_cnt <= '0;
               r_rnd <= '0;
               r_dec <= dec;
            end
            S_ARK: begin
               r_rio <= w_ark;
               r_cnt <= r_cnt == 4'(ARK_CYC-1) ? '0 : r_cnt + 4'd1;
               if (r_cnt == 4'(ARK_CYC-1)) r_st <= S_LKP;
            end
            S_LKP: if (r_cnt == 4'(RD_LAT-1)) begin
               r_rio <= w_lkp;
               r_vld <= 1'b1;
               r_cnt <= '0;
               if (r_rnd == 4'(NR)) begin
                  r_st   <= S_IDLE;
                  r_done <= 1'b1;
               end else begin
                  r_st  <= S_ARK;
                  r_rnd <= r_rnd + 4'd1;
               end
            end else r_cnt <= r_cnt + 4'd1;
            default: r_st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cim_aes_array_model.sv
// tb_cim_aes_array_model: default (RD_LAT=1) and RD_LAT=3 instances share stimulus;
// expected outputs come from the per-cycle round/phase arithmetic of the block.
module tb_cim_aes_array_model;
   localparam int NR = 10, ARK = 8;

   logic CLK = 0, RSTn = 0, start = 0, dec = 0, key_we = 0, tbl_we = 0;
   logic [3:0]   key_idx = '0;
   logic [127:0] key_wdata = '0;
   logic [7:0]   tbl_addr = '0, tbl_wdata = '0;
   logic [15:0]  IN = '0;
   logic [47:0]  demux_add = '0;
   logic [95:0]  rwl_add = '0;
   logic [127:0] rio0, rio1;
   logic         ark0, ark1, vld0, vld1, busy0, busy1, done0, done1, err0, err1;
   logic [3:0]   rnd0, rnd1;

   logic [7:0]   tb_tbl [0:255];
   logic [127:0] tb_key [0:NR];
   logic [127:0] exp_rio [0:1];
   logic [15:0]  in_h [0:127];
   logic [47:0]  dm_h [0:127];
   logic [95:0]  rw_h [0:127];
   int           vcnt [0:1];
   int           dcyc [0:1];
   int           n_tests = 0, n_fail = 0;

   cim_aes_array_model dut (
      .CLK(CLK), .RSTn(RSTn), .start(start), .dec(dec), .key_we(key_we), .key_idx(key_idx),
      .key_wdata(key_wdata), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .IN(IN), .demux_add(demux_add), .rwl_add(rwl_add), .rio(rio0), .ark_phase(ark0),
      .lkp_vld(vld0), .rnd(rnd0), .busy(busy0), .done(done0), .wr_err(err0));

   cim_aes_array_model #(.RD_LAT(3)) dut3 (
      .CLK(CLK), .RSTn(RSTn), .start(start), .dec(dec), .key_we(key_we), .key_idx(key_idx),
      .key_wdata(key_wdata), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
      .IN(IN), .demux_add(demux_add), .rwl_add(rwl_add), .rio(rio1), .ark_phase(ark1),
      .lkp_vld(vld1), .rnd(rnd1), .busy(busy1), .done(done1), .wr_err(err1));

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Lane j < 8 gathers bit j of even bytes; lane j >= 8 bit j-8 of odd bytes, byte 0 first.
   function automatic logic [127:0] ark_all(logic [127:0] key, logic [15:0] din);
      logic [127:0] r;
      logic [7:0]   b;
      int           k, h;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         k = j % 8;
         h = j / 8;
         for (int i = 0; i < 8; i++) begin
            b = key[127 - 8*(2*i + h) -: 8];
            r[j*8 + 7 - i] = b[k] ^ din[h ? k : k + 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] lkp_all(int c);
      logic [127:0] r;
      logic [8:0]   a9;
      r = '0;
      for (int j = 0; j < 16; j++) begin
         a9 = {dm_h[c][j*3 +: 3], rw_h[c][j*6 +: 6]};
         r[j*8 +: 8] = tb_tbl[a9[7:0]];
      end
      return r;
   endfunction

   task automatic chk_outs(int i, int c, logic [127:0] er, logic ev, logic dn, logic bs,
                           logic ak, logic [3:0] rn, logic we);
      chk($sformatf("c%0d i%0d rio", c, i), i != 0 ? rio1 : rio0, er);
      chk($sformatf("c%0d i%0d lkp_vld", c, i), i != 0 ? vld1 : vld0, ev);
      chk($sformatf("c%0d i%0d done", c, i), i != 0 ? done1 : done0, dn);
      chk($sformatf("c%0d i%0d busy", c, i), i != 0 ? busy1 : busy0, bs);
      chk($sformatf("c%0d i%0d ark_phase", c, i), i != 0 ? ark1 : ark0, ak);
      chk($sformatf("c%0d i%0d rnd", c, i), i != 0 ? rnd1 : rnd0, rn);
      chk($sformatf("c%0d i%0d wr_err", c, i), i != 0 ? err1 : err0, we);
   endtask

   task automatic run_seq(logic dv, bit fixed, int rst_at, int werr_at, bit wk0);
      int L, P, T, r, pos;
      logic ev, dn, bs, ak, we;
      logic [3:0] rn;
      start = 1;
      dec = dv;
      if (wk0) begin
         key_we = 1;
         key_idx = 0;
         key_wdata = rnd128();
         tb_key[0] = key_wdata;
      end
      tick;
      start = 0;
      key_we = 0;
      dec = ~dv;
      for (int i = 0; i < 2; i++) begin
         vcnt[i] = 0;
         dcyc[i] = 0;
         chk_outs(i, 0, exp_rio[i], 0, 0, 1, 1, 0, 0);
      end
      for (int c = 1; c < 126; c++) begin
         IN = (fixed && c == 1) ? 16'h0000 : (fixed && c == 2) ? 16'h0101 : 16'($urandom);
         demux_add = {16'($urandom), $urandom};
         rwl_add = {$urandom, $urandom, $urandom};
         if (fixed && c <= 11) begin
            demux_add[5:0] = 6'b101_000;
            rwl_add[11:0] = {6'h3f, 6'h13};
         end
         start = c == 5;
         dec = 1;
         key_we = c == werr_at;
         key_idx = 4;
         key_wdata = rnd128();
         RSTn = c != rst_at;
         in_h[c] = IN;
         dm_h[c] = demux_add;
         rw_h[c] = rwl_add;
         tick;
         for (int i = 0; i < 2; i++) begin
            L = i != 0 ? 3 : 1;
            P = ARK + L;
            T = (NR + 1) * P;
            if (c == rst_at) begin
               exp_rio[i] = '0;
               {ev, dn, bs, ak, we} = '0;
               rn = 0;
            end else if (c <= T) begin
               r = (c - 1) / P;
               pos = (c - 1) % P;
               if (pos < ARK) exp_rio[i] = ark_all(tb_key[dv ? NR - r : r], in_h[c]);
               ev = pos == P - 1;
               if (ev) exp_rio[i] = lkp_all(c - (L - 1));
               dn = c == T;
               bs = c != T;
               ak = c != T && (c % P) < ARK;
               rn = c == T ? 4'(NR) : 4'(c / P);
               we = c == werr_at;
            end else begin
               {ev, dn, bs, ak, we} = '0;
               rn = 4'(NR);
            end
            if (i != 0 ? vld1 : vld0) vcnt[i]++;
            if (i != 0 ? done1 : done0) dcyc[i] = c;
            chk_outs(i, c, exp_rio[i], ev, dn, bs, ak, rn, we);
         end
         if (fixed && !dv && c == 1) begin
            chk("tp lane0 IN=0", rio0[7:0], 8'h00);
            chk("tp lane1 IN=0", rio0[15:8], 8'h55);
            chk("tp lane8 IN=0", rio0[71:64], 8'hff);
         end
         if (fixed && !dv && c == 2) begin
            chk("tp lane8 IN[0]", rio0[71:64], 8'h00);
            chk("tp lane0 IN[8]", rio0[7:0], 8'hff);
         end
         if (fixed && dv && c == 1) chk("tp dec lane0", rio0[7:0], 8'hee);
         if (fixed && c == 9) chk("tp lkp lat1", rio0[15:0], 16'hd27d);
         if (fixed && c == 11) chk("tp lkp lat3", rio1[15:0], 16'hd27d);
         if (c == rst_at) break;
      end
      start = 0;
      key_we = 0;
      RSTn = 1;
      if (rst_at == 0) begin
         chk("vld count lat1", vcnt[0], NR + 1);
         chk("vld count lat3", vcnt[1], NR + 1);
         chk("done cycle lat1", dcyc[0], 99);
         chk("done cycle lat3", dcyc[1], 121);
      end
   endtask

   initial begin
      logic [2047:0] sb_v;
      sb_v = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
              128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
              128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
              128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
              128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
              128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
              128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
              128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      exp_rio[0] = '0;
      exp_rio[1] = '0;
      RSTn = 0;
      repeat (3) tick;
      for (int i = 0; i < 2; i++) chk_outs(i, 0, '0, 0, 0, 0, 0, 0, 0);
      RSTn = 1;
      tbl_we = 1;
      for (int a = 0; a < 256; a++) begin
         tb_tbl[a] = sb_v[2047 - 8*a -: 8];
         tbl_addr = 8'(a);
         tbl_wdata = tb_tbl[a];
         tick;
      end
      tbl_we = 0;
      key_we = 1;
      for (int k = 0; k <= NR; k++) begin
         tb_key[k] = k == 0 ? 128'h000102030405060708090a0b0c0d0e0f :
                     k == NR ? 128'h13111d7fe3944a17f307a78b4d2b30c5 : rnd128();
         key_idx = 4'(k);
         key_wdata = tb_key[k];
         tick;
      end
      key_idx = 15;
      key_wdata = rnd128();
      tick;
      key_we = 0;
      run_seq(0, 1, 0, 0, 0);
      run_seq(1, 1, 0, 0, 0);
      run_seq(0, 0, 40, 3, 0);
      for (int w = 0; w < 3; w++) begin
         tick;
         for (int i = 0; i < 2; i++) chk_outs(i, 200 + w, '0, 0, 0, 0, 0, 0, 0);
      end
      run_seq(0, 0, 0, 7, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
